// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg
// Shared definitions for the seven-segment scan driver:
//   DIGIT_COUNT   - number of scanned digits
//   SEG_HEX_0..F  - active-low {g,f,e,d,c,b,a} patterns for hex digits
//   SEG_OFF       - all segments (including DP) off
//   scan_state_t  - scan FSM states
package seven_segment_pkg;

  localparam int DIGIT_COUNT = 8;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

endpackage

// File: rtl/segment_scan_driver_hex_to_segments.sv
// hex_to_segments
// Combinational hex nibble to active-low seven-segment decoder.
// Ports:
//   nibble   in  [3:0]  hex value
//   segments out [6:0]  active-low {g,f,e,d,c,b,a}
module hex_to_segments
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_HEX_0;
    case (nibble)
      4'h0: segments = SEG_HEX_0;
      4'h1: segments = SEG_HEX_1;
      4'h2: segments = SEG_HEX_2;
      4'h3: segments = SEG_HEX_3;
      4'h4: segments = SEG_HEX_4;
      4'h5: segments = SEG_HEX_5;
      4'h6: segments = SEG_HEX_6;
      4'h7: segments = SEG_HEX_7;
      4'h8: segments = SEG_HEX_8;
      4'h9: segments = SEG_HEX_9;
      4'hA: segments = SEG_HEX_A;
      4'hB: segments = SEG_HEX_B;
      4'hC: segments = SEG_HEX_C;
      4'hD: segments = SEG_HEX_D;
      4'hE: segments = SEG_HEX_E;
      4'hF: segments = SEG_HEX_F;
      default: segments = SEG_HEX_0;
    endcase
  end

endmodule

// File: rtl/segment_scan_driver.sv
// segment_scan_driver
// Time-multiplexed driver for an 8-digit seven-segment display. Each digit is
// preceded by a blanking interval; data and decimal points are snapshotted
// once per frame so a frame never mixes old and new values.
// Parameters:
//   TICKS_PER_DIGIT  cycles each digit is driven (>= 1)
//   BLANK_TICKS      cycles all digits are off before each digit (>= 1)
// Ports:
//   clock           in       rising-edge clock
//   reset           in       synchronous, active-high
//   data            in  [31:0] nibble i is the hex value of digit i
//   pointEnable     in  [7:0]  bit i lights the DP of digit i
//   segmentEnableN  out [7:0]  active-low {dp,g,f,e,d,c,b,a}
//   digitEnableN    out [7:0]  active-low one-cold digit select
//   frameStart      out        pulse in the cycle after the snapshot load
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          non-zero nibble have their segments blanked
//                          (DP still shown, digit 0 never blanked).
module segment_scan_driver
  import seven_segment_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic [7:0]  pointEnable,
  output logic [7:0]  segmentEnableN,
  output logic [7:0]  digitEnableN,
  output logic        frameStart
);

  localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int IDX_W     = $clog2(DIGIT_COUNT);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

  scan_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      data_snap;
  logic [7:0]       point_snap;

  logic             load_snap;
  logic [3:0]       nibble;
  logic [6:0]       hex_seg;
  logic [6:0]       digit_seg;

  // The first BLANK cycle of digit 0 opens a new frame.
  assign load_snap = (state == BLANK) && (idx == '0) && (cnt == '0);
  assign nibble    = data_snap[4*idx +: 4];

  hex_to_segments u_hex (
    .nibble   (nibble),
    .segments (hex_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Current nibble and every nibble above it are zero.
  assign upper_zero = (data_snap >> {idx, 2'b00}) == 32'd0;
  assign digit_seg  = ((idx != '0) && upper_zero) ? 7'h7F : hex_seg;
`else
  assign digit_seg  = hex_seg;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= BLANK;
      idx            <= '0;
      cnt            <= '0;
      data_snap      <= '0;
      point_snap     <= '0;
      segmentEnableN <= SEG_OFF;
      digitEnableN   <= 8'hFF;
      frameStart     <= 1'b0;
    end else begin
      frameStart <= load_snap;
      if (load_snap) begin
        data_snap  <= data;
        point_snap <= pointEnable;
      end

      case (state)
        BLANK: begin
          segmentEnableN <= SEG_OFF;
          digitEnableN   <= 8'hFF;
          if (cnt == BLANK_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          segmentEnableN <= {~point_snap[idx], digit_seg};
          digitEnableN   <= ~(8'b1 << idx);
          if (cnt == DRIVE_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= idx + IDX_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/segment_scan_driver.md
# segment_scan_driver

Time-multiplexed display driver for the 8-digit seven-segment display. Consumes the 32-bit hex data word and 8-bit decimal-point mask produced by the top-level input logic. It scans one digit at a time and drives the active-low segment and digit-enable pins. Inter-digit blanking suppresses ghosting, and a per-frame input snapshot prevents tearing.

## Interface
- `TICKS_PER_DIGIT`, default 100000: clock cycles each digit is driven (≥1).
- `BLANK_TICKS`, default 1000: clock cycles all digits are off before each digit (≥1).
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `data` input 32: nibble i (`data[4i+3:4i]`) is the hex value for digit i.
- `pointEnable` input 8: bit i lights the decimal point of digit i.
- `segmentEnableN` output 8: active-low segments; bit 7 = DP, bits 6:0 = g,f,e,d,c,b,a.
- `digitEnableN` output 8: active-low one-cold digit select; bit i = digit i.
- `frameStart` output 1: one-cycle pulse marking snapshot load.

One clock; reset is synchronous and active-high.

## Operation
- The FSM has two states.
  - BLANK: drives all outputs off and runs `BLANK_TICKS` cycles.
  - DRIVE: drives digit `idx` and runs `TICKS_PER_DIGIT` cycles.
- Transitions:
  - BLANK → DRIVE when `cnt == BLANK_TICKS-1`.
  - DRIVE → BLANK when `cnt == TICKS_PER_DIGIT-1`; at the same time `idx` increments, wrapping 7 → 0.
  - `cnt` clears on every transition.
- Snapshot: `dataSnap`/`pointSnap` load from `data`/`pointEnable` in the cycle where state == BLANK, `idx == 0` and `cnt == 0`. This includes the first cycle after reset deasserts. Input changes at any other time are invisible until the next frame.
- DRIVE outputs:
  - `digitEnableN = ~(8'b1 << idx)`.
  - `segmentEnableN[6:0]` = active-low hex pattern of `dataSnap` nibble `idx`.
  - `segmentEnableN[7] = ~pointSnap[idx]`.
- BLANK outputs: `segmentEnableN = 8'hFF`, `digitEnableN = 8'hFF`.
- Arithmetic: `cnt` width = `$clog2(max(TICKS_PER_DIGIT, BLANK_TICKS))`, minimum 1 bit. `idx` is 3 bits with natural wrap.
- Reset values:
  - State BLANK, `idx = 0`, `cnt = 0`, snapshots `0`.
  - `segmentEnableN = 8'hFF`, `digitEnableN = 8'hFF`, `frameStart = 0`.
- Reset mid-operation (any state) forces the reset values on the next edge. No partial digit is completed.

## Timing
- All outputs are registered. Output changes appear 1 cycle after the internal state/idx change.
- `frameStart` is high for exactly the cycle after the snapshot-load cycle.
- Frame period = 8·(`BLANK_TICKS` + `TICKS_PER_DIGIT`) cycles. `frameStart` recurs at exactly this spacing.
- Reset release to first digit-0 drive on the pins = `BLANK_TICKS` + 1 cycles.
- Digit enable is never low while BLANK is active. Adjacent digits are never enabled in the same cycle.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined: digit i (i ≥ 1) has segments 6:0 forced off (1) when `dataSnap` nibbles i..7 are all zero. The DP still follows `pointSnap[i]` and the digit is still enabled. Digit 0 is never blanked.
  - Undefined: every digit shows its nibble, including zeros.

## Structure
- Package `seven_segment_pkg`:
  - `DIGIT_COUNT = 8`.
  - 16 active-low 7-bit hex segment constants, 0–F: 0=`7'h40`, 4=`7'h19`, A=`7'h08`.
  - `SEG_OFF = 8'hFF`.
  - Scan state enum {BLANK, DRIVE}.
- Sub-module `hex_to_segments`: combinational 4-bit → 7-bit active-low decoder using the package constants. It is instantiated once on the muxed nibble.

## Test plan
Bench parameters: `TICKS_PER_DIGIT=4`, `BLANK_TICKS=2`.
- Reset asserted during digit 3 DRIVE → next cycle `segmentEnableN=8'hFF`, `digitEnableN=8'hFF`, `frameStart=0`. After release, first `frameStart` comes 1 cycle after the load cycle.
- `data=32'h0000_1234`, `pointEnable=0` → digit 0 drives `digitEnableN=8'hFE`, `segmentEnableN=8'h99` for 4 cycles. Digit 1 gives `8'hFD`/`8'hB0`. Each digit is preceded by 2 cycles of `8'hFF`/`8'hFF`.
- `pointEnable=8'h04`, `data=0` → only during digit 2 is `segmentEnableN[7]=0` (`8'h40`). All other digits show `8'hC0`.
- Change `data` from `32'h1111_1111` to `32'h2222_2222` while digit 3 is driven → digits 4–7 still show `8'hF9`. `8'hA4` appears only after the next `frameStart`.
- `frameStart` pulses at 48-cycle intervals over 3 consecutive frames.
- `data=32'h0000_00A0`, macro defined → digits 2–7 `segmentEnableN=8'hFF`, digit 1 `8'h88`, digit 0 `8'hC0`. Macro undefined → digits 2–7 `8'hC0`.
